// File: rtl/digit_border_projection_if.sv
// Bundles the binarized pixel stream and the two border-file read ports of
// digit_border_projection.
//   pix_valid/monoc/xpos/ypos : pixel stream into the projector
//   row_border_addr/data      : combinational read of the row border file
//   col_border_addr/data      : combinational read of the column border file
// master = stream source / recognizer side, slave = the projector.
interface digit_border_projection_if;
  logic        pix_valid;
  logic        monoc;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic [10:0] row_border_addr;
  logic [10:0] row_border_data;
  logic [10:0] col_border_addr;
  logic [10:0] col_border_data;

  modport master (
    output pix_valid, monoc, xpos, ypos, row_border_addr, col_border_addr,
    input  row_border_data, col_border_data
  );

  modport slave (
    input  pix_valid, monoc, xpos, ypos, row_border_addr, col_border_addr,
    output row_border_data, col_border_data
  );
endinterface

// File: rtl/digit_border_projection.sv
// Projects one frame out of every four onto the Y axis (rows) and X axis
// (columns), finds the foreground segment borders and stores them in two
// border register files read combinationally by the digit recognizer.
// Ports:
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   bus (slave)       : pixel stream in, border-file read ports out
//   frame_cnt         : frame phase 0..3, advances at every frame end
//   project_done_flag : borders and counts are valid
//   num_row, num_col  : number of stored row / column segments
//   seg_overflow      : more valid segments seen than could be stored
module digit_border_projection #(
  parameter int H_PIXEL  = 480,
  parameter int V_PIXEL  = 272,
  parameter int MAX_ROW  = 4,
  parameter int MAX_COL  = 8,
  parameter int MIN_SEG  = 2,
  parameter bit FG_LEVEL = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  digit_border_projection_if.slave        bus,
  output logic [1:0]                      frame_cnt,
  output logic                            project_done_flag,
  output logic [3:0]                      num_row,
  output logic [3:0]                      num_col,
  output logic                            seg_overflow
);

  localparam int          XW      = $clog2(H_PIXEL);
  localparam int          RA_W    = $clog2(2 * MAX_ROW);
  localparam int          CA_W    = $clog2(2 * MAX_COL);
  localparam logic [10:0] X_LAST  = 11'(H_PIXEL - 1);
  localparam logic [10:0] Y_LAST  = 11'(V_PIXEL - 1);
  localparam logic [10:0] MIN_LEN = 11'(MIN_SEG);

  typedef enum logic [1:0] {ST_ACCUM, ST_SCAN, ST_DONE} state_t;

  state_t              state;
  logic [10:0]         row_file [2*MAX_ROW];
  logic [10:0]         col_file [2*MAX_COL];
  logic [H_PIXEL-1:0]  col_flag;

  logic                line_fg, prev_fg;
  logic [10:0]         row_start;
  logic [3:0]          row_cnt, col_cnt;
  logic                ovf;
  logic                col_prev;
  logic [10:0]         col_start;
  logic [10:0]         scan_x;
  logic                rd_vld, rd_flag;
  logic [10:0]         rd_x;

  // Pixel stream events.
  logic fg, sof, line_end, frame_end;
  assign fg        = bus.pix_valid && (bus.monoc == FG_LEVEL);
  assign sof       = bus.pix_valid && (bus.xpos == 11'd0) && (bus.ypos == 11'd0);
  assign line_end  = bus.pix_valid && (bus.xpos == X_LAST);
  assign frame_end = line_end && (bus.ypos == Y_LAST);

  // Row segment detection. line_fg from a previous frame is ignored on the
  // first pixel so a stale value can never leak into line 0.
  logic        row_cur, row_close, row_keep;
  logic [10:0] row_lo, row_hi;
  assign row_cur   = (sof ? 1'b0 : line_fg) | fg;
  assign row_lo    = prev_fg ? row_start : bus.ypos;
  // A segment still open on the last line closes at the bottom edge.
  assign row_hi    = row_cur ? Y_LAST : bus.ypos - 11'd1;
  assign row_close = line_end && ((prev_fg && !row_cur) || (frame_end && row_cur));
  assign row_keep  = (row_hi - row_lo + 11'd1) >= MIN_LEN;

  // Column segment detection on the flag read back one cycle earlier.
  logic        col_close, col_keep;
  logic [10:0] col_lo, col_hi;
  assign col_lo    = col_prev ? col_start : rd_x;
  assign col_hi    = rd_flag ? X_LAST : rd_x - 11'd1;
  assign col_close = rd_vld && ((col_prev && !rd_flag) || (rd_flag && rd_x == X_LAST));
  assign col_keep  = (col_hi - col_lo + 11'd1) >= MIN_LEN;

  // Combinational read ports; out-of-range addresses read as zero.
  assign bus.row_border_data = (bus.row_border_addr < 11'(2 * MAX_ROW))
                               ? row_file[bus.row_border_addr[RA_W-1:0]] : 11'd0;
  assign bus.col_border_data = (bus.col_border_addr < 11'(2 * MAX_COL))
                               ? col_file[bus.col_border_addr[CA_W-1:0]] : 11'd0;

  // NOTE: the column-flag memory has no reset; line 0 of every projected
  // frame overwrites each flag before it is ever ORed into or scanned.
  always_ff @(posedge clk) begin
    if (state == ST_ACCUM && bus.pix_valid && bus.xpos < 11'(H_PIXEL))
      col_flag[bus.xpos[XW-1:0]] <= (bus.ypos == 11'd0)
                                    ? fg : (col_flag[bus.xpos[XW-1:0]] | fg);
  end

  // NOTE: all sequential state uses non-blocking assignments, so the later
  // conditional file writes below cleanly override the frame-start clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_ACCUM;
      frame_cnt         <= 2'd0;
      project_done_flag <= 1'b0;
      num_row           <= 4'd0;
      num_col           <= 4'd0;
      seg_overflow      <= 1'b0;
      line_fg           <= 1'b0;
      prev_fg           <= 1'b0;
      row_start         <= 11'd0;
      row_cnt           <= 4'd0;
      col_cnt           <= 4'd0;
      ovf               <= 1'b0;
      col_prev          <= 1'b0;
      col_start         <= 11'd0;
      scan_x            <= 11'd0;
      rd_vld            <= 1'b0;
      rd_flag           <= 1'b0;
      rd_x              <= 11'd0;
      for (int i = 0; i < 2*MAX_ROW; i++) row_file[i] <= 11'd0;
      for (int i = 0; i < 2*MAX_COL; i++) col_file[i] <= 11'd0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 2'd1;

      case (state)
        ST_ACCUM: begin
          if (sof) begin
            row_cnt <= 4'd0;
            ovf     <= 1'b0;
            prev_fg <= 1'b0;
            for (int i = 0; i < 2*MAX_ROW; i++) row_file[i] <= 11'd0;
            for (int i = 0; i < 2*MAX_COL; i++) col_file[i] <= 11'd0;
          end
          if (bus.pix_valid) begin
            line_fg <= line_end ? 1'b0 : row_cur;
            if (line_end) begin
              prev_fg <= row_cur;
              if (row_cur && !prev_fg) row_start <= bus.ypos;
              if (row_close && row_keep) begin
                if (row_cnt < 4'(MAX_ROW)) begin
                  row_file[RA_W'({row_cnt, 1'b0})] <= row_lo;
                  row_file[RA_W'({row_cnt, 1'b1})] <= row_hi;
                  row_cnt <= row_cnt + 4'd1;
                end else begin
                  ovf <= 1'b1;
                end
              end
            end
          end
          if (frame_end) begin
            state    <= ST_SCAN;
            scan_x   <= 11'd0;
            col_cnt  <= 4'd0;
            col_prev <= 1'b0;
            rd_vld   <= 1'b0;
          end
        end

        ST_SCAN: begin
          // Read stage: flag x is fetched while flag x-1 is evaluated.
          scan_x  <= scan_x + 11'd1;
          rd_vld  <= scan_x < 11'(H_PIXEL);
          rd_x    <= scan_x;
          rd_flag <= (scan_x < 11'(H_PIXEL)) && col_flag[scan_x[XW-1:0]];
          if (rd_vld) begin
            col_prev <= rd_flag;
            if (rd_flag && !col_prev) col_start <= rd_x;
            if (col_close && col_keep) begin
              if (col_cnt < 4'(MAX_COL)) begin
                col_file[CA_W'({col_cnt, 1'b0})] <= col_lo;
                col_file[CA_W'({col_cnt, 1'b1})] <= col_hi;
                col_cnt <= col_cnt + 4'd1;
              end else begin
                ovf <= 1'b1;
              end
            end
          end
          if (scan_x == 11'(H_PIXEL + 1)) begin
            num_row           <= row_cnt;
            num_col           <= col_cnt;
            seg_overflow      <= ovf;
            project_done_flag <= 1'b1;
            state             <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (frame_end && frame_cnt == 2'd3) begin
            project_done_flag <= 1'b0;
            state             <= ST_ACCUM;
          end
        end

        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_border_projection.sv
// Directed bench for digit_border_projection on a reduced 64x32 frame so that
// whole projected frames stay short. Frames that are not projected are
// represented only by their frame-end pixel.
module tb_digit_border_projection;
  localparam int TH = 64;
  localparam int TV = 32;
  localparam bit FG = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] frame_cnt;
  logic       project_done_flag;
  logic [3:0] num_row, num_col;
  logic       seg_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_border_projection_if bus ();

  digit_border_projection #(
    .H_PIXEL(TH), .V_PIXEL(TV), .MAX_ROW(4), .MAX_COL(8), .MIN_SEG(2), .FG_LEVEL(FG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .frame_cnt(frame_cnt),
    .project_done_flag(project_done_flag),
    .num_row(num_row),
    .num_col(num_col),
    .seg_overflow(seg_overflow)
  );

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drives one full frame: pixel (x,y) is ink when rmask[y] && cmask[x], or
  // when it is the optional single extra pixel (nx,ny).
  task automatic send_frame(input logic [63:0] rmask, input logic [63:0] cmask,
                            input int nx, input int ny);
    for (int y = 0; y < TV; y++) begin
      for (int x = 0; x < TH; x++) begin
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.xpos      = 11'(x);
        bus.ypos      = 11'(y);
        bus.monoc     = ((rmask[y] && cmask[x]) || (x == nx && y == ny)) ? FG : ~FG;
      end
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic advance_frame();
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.xpos      = 11'(TH - 1);
    bus.ypos      = 11'(TV - 1);
    bus.monoc     = ~FG;
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!project_done_flag && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (project_done_flag !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: flag=%b after %0d cycles, required 1", name, project_done_flag, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.row_border_addr = 11'd0;
    bus.col_border_addr = 11'd1;
    #1;
    checks++;
    if ({frame_cnt, project_done_flag, num_row, num_col, seg_overflow} !== 12'd0) begin
      failures++;
      $display("FAIL reset_status: cnt=%0d flag=%b rows=%0d cols=%0d ovf=%b, required all 0",
               frame_cnt, project_done_flag, num_row, num_col, seg_overflow);
    end
    checks++;
    if (bus.row_border_data !== 11'd0 || bus.col_border_data !== 11'd0) begin
      failures++;
      $display("FAIL reset_files: row=%0d col=%0d, required 0 0", bus.row_border_data, bus.col_border_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    logic [10:0] exp_r [2] = '{11'd10, 11'd19};
    logic [10:0] exp_c [2] = '{11'd20, 11'd29};
    send_frame(span(10, 19), span(20, 29), -1, -1);
    checks++;
    if (project_done_flag !== 1'b0 || frame_cnt !== 2'd1) begin
      failures++;
      $display("FAIL single_scan_start: flag=%b cnt=%0d, required 0 1", project_done_flag, frame_cnt);
    end
    wait_done("single");
    checks++;
    if (num_row !== 4'd1 || num_col !== 4'd1 || seg_overflow !== 1'b0) begin
      failures++;
      $display("FAIL single_counts: rows=%0d cols=%0d ovf=%b, required 1 1 0", num_row, num_col, seg_overflow);
    end
    for (int i = 0; i < 2; i++) begin
      bus.row_border_addr = 11'(i);
      bus.col_border_addr = 11'(i);
      #1;
      checks++;
      if (bus.row_border_data !== exp_r[i] || bus.col_border_data !== exp_c[i]) begin
        failures++;
        $display("FAIL single_file[%0d]: row=%0d col=%0d, required %0d %0d",
                 i, bus.row_border_data, bus.col_border_data, exp_r[i], exp_c[i]);
      end
    end
    for (int f = 2; f <= 4; f++) begin
      advance_frame();
      checks++;
      if (frame_cnt !== 2'(f) || project_done_flag !== (f < 4)) begin
        failures++;
        $display("FAIL single_phase%0d: cnt=%0d flag=%b, required %0d %b",
                 f, frame_cnt, project_done_flag, f % 4, f < 4);
      end
    end
  endtask

  task automatic test_three_digits();
    logic [10:0] exp_c [6] = '{11'd5, 11'd9, 11'd20, 11'd24, 11'd40, 11'd44};
    send_frame(span(8, 20), span(5, 9) | span(20, 24) | span(40, 44), -1, -1);
    wait_done("three");
    checks++;
    if (num_row !== 4'd1 || num_col !== 4'd3) begin
      failures++;
      $display("FAIL three_counts: rows=%0d cols=%0d, required 1 3", num_row, num_col);
    end
    for (int i = 0; i < 6; i++) begin
      bus.col_border_addr = 11'(i);
      #1;
      checks++;
      if (bus.col_border_data !== exp_c[i]) begin
        failures++;
        $display("FAIL three_col[%0d]: got %0d, required %0d", i, bus.col_border_data, exp_c[i]);
      end
    end
    advance_frame();
    advance_frame();
    checks++;
    if (frame_cnt !== 2'd3 || project_done_flag !== 1'b1) begin
      failures++;
      $display("FAIL three_phase3: cnt=%0d flag=%b, required 3 1", frame_cnt, project_done_flag);
    end
    advance_frame();
    checks++;
    if (frame_cnt !== 2'd0 || project_done_flag !== 1'b0) begin
      failures++;
      $display("FAIL three_wrap: cnt=%0d flag=%b, required 0 0", frame_cnt, project_done_flag);
    end
  endtask

  task automatic test_noise();
    // Column 3 and the lone pixel (50,2) are one pixel wide / one line tall.
    send_frame(span(5, 10), span(3, 3) | span(10, 30), 50, 2);
    wait_done("noise");
    bus.row_border_addr = 11'd0;
    bus.col_border_addr = 11'd0;
    #1;
    checks++;
    if (num_row !== 4'd1 || num_col !== 4'd1 || bus.row_border_data !== 11'd5 || bus.col_border_data !== 11'd10) begin
      failures++;
      $display("FAIL noise_low: rows=%0d cols=%0d top=%0d left=%0d, required 1 1 5 10",
               num_row, num_col, bus.row_border_data, bus.col_border_data);
    end
    bus.row_border_addr = 11'd1;
    bus.col_border_addr = 11'd1;
    #1;
    checks++;
    if (bus.row_border_data !== 11'd10 || bus.col_border_data !== 11'd30) begin
      failures++;
      $display("FAIL noise_high: bottom=%0d right=%0d, required 10 30", bus.row_border_data, bus.col_border_data);
    end
    repeat (3) advance_frame();
  endtask

  task automatic test_overflow();
    logic [63:0] cm = '0;
    for (int s = 0; s < 10; s++) cm = cm | span(4*s, 4*s + 2);
    send_frame(span(3, 6) | span(10, 12), cm, -1, -1);
    wait_done("ovf");
    checks++;
    if (num_row !== 4'd2 || num_col !== 4'd8 || seg_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_counts: rows=%0d cols=%0d ovf=%b, required 2 8 1", num_row, num_col, seg_overflow);
    end
    for (int i = 0; i < 18; i++) begin
      bus.col_border_addr = 11'(i);
      #1;
      checks++;
      if (bus.col_border_data !== ((i < 16) ? 11'(2*i) : 11'd0)) begin
        failures++;
        $display("FAIL ovf_col[%0d]: got %0d, required %0d", i, bus.col_border_data, (i < 16) ? 2*i : 0);
      end
    end
    bus.row_border_addr = 11'd3;
    #1;
    checks++;
    if (bus.row_border_data !== 11'd12) begin
      failures++;
      $display("FAIL ovf_row3: got %0d, required 12", bus.row_border_data);
    end
    repeat (3) advance_frame();
  endtask

  task automatic test_edges_and_empty();
    logic [10:0] exp_r [4] = '{11'd0, 11'd1, 11'd22, 11'd31};
    logic [10:0] exp_c [4] = '{11'd0, 11'd1, 11'd50, 11'd63};
    send_frame(span(0, 1) | span(22, 31), span(0, 1) | span(50, 63), -1, -1);
    wait_done("edge");
    checks++;
    if (num_row !== 4'd2 || num_col !== 4'd2 || seg_overflow !== 1'b0) begin
      failures++;
      $display("FAIL edge_counts: rows=%0d cols=%0d ovf=%b, required 2 2 0", num_row, num_col, seg_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      bus.row_border_addr = 11'(i);
      bus.col_border_addr = 11'(i);
      #1;
      checks++;
      if (bus.row_border_data !== exp_r[i] || bus.col_border_data !== exp_c[i]) begin
        failures++;
        $display("FAIL edge_file[%0d]: row=%0d col=%0d, required %0d %0d",
                 i, bus.row_border_data, bus.col_border_data, exp_r[i], exp_c[i]);
      end
    end
    repeat (3) advance_frame();
    send_frame('0, '0, -1, -1);
    wait_done("empty");
    bus.row_border_addr = 11'd1;
    bus.col_border_addr = 11'd3;
    #1;
    checks++;
    if (num_row !== 4'd0 || num_col !== 4'd0 || seg_overflow !== 1'b0 ||
        bus.row_border_data !== 11'd0 || bus.col_border_data !== 11'd0) begin
      failures++;
      $display("FAIL empty: rows=%0d cols=%0d ovf=%b row1=%0d col3=%0d, required all 0",
               num_row, num_col, seg_overflow, bus.row_border_data, bus.col_border_data);
    end
    repeat (3) advance_frame();
  endtask

  task automatic test_reset_mid_scan();
    send_frame(span(4, 7), span(8, 9), -1, -1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.row_border_addr = 11'd0;
    bus.col_border_addr = 11'd0;
    #1;
    checks++;
    if ({frame_cnt, project_done_flag, num_row, num_col} !== 11'd0 ||
        bus.row_border_data !== 11'd0 || bus.col_border_data !== 11'd0) begin
      failures++;
      $display("FAIL midscan_reset: cnt=%0d flag=%b rows=%0d cols=%0d row0=%0d col0=%0d, required all 0",
               frame_cnt, project_done_flag, num_row, num_col, bus.row_border_data, bus.col_border_data);
    end
    send_frame(span(12, 14), span(30, 31), -1, -1);
    wait_done("reproject");
    bus.row_border_addr = 11'd1;
    bus.col_border_addr = 11'd0;
    #1;
    checks++;
    if (num_row !== 4'd1 || num_col !== 4'd1 || frame_cnt !== 2'd1 ||
        bus.row_border_data !== 11'd14 || bus.col_border_data !== 11'd30) begin
      failures++;
      $display("FAIL reproject: rows=%0d cols=%0d cnt=%0d bottom=%0d left=%0d, required 1 1 1 14 30",
               num_row, num_col, frame_cnt, bus.row_border_data, bus.col_border_data);
    end
  endtask

  initial begin
    bus.pix_valid       = 1'b0;
    bus.monoc           = ~FG;
    bus.xpos            = 11'd0;
    bus.ypos            = 11'd0;
    bus.row_border_addr = 11'd0;
    bus.col_border_addr = 11'd0;
    test_reset();
    test_single_block();
    test_three_digits();
    test_noise();
    test_overflow();
    test_edges_and_empty();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/digit_border_projection.md
Name: digit_border_projection

Overview:
- Upstream stage of the digit recognizer. Projects the binarized video stream onto the Y axis (rows) and the X axis (columns) during one frame of every four.
- Finds the foreground segment borders and stores them in two border register files, which the recognizer reads combinationally.
- Publishes num_row/num_col, a 2-bit frame phase counter and project_done_flag. The recognizer uses these to box and classify digits in later frames.

Parameters:
H_PIXEL, 480, active pixels per line
V_PIXEL, 272, active lines per frame
MAX_ROW, 4, max row segments stored (≤15)
MAX_COL, 8, max column segments stored (≤15)
MIN_SEG, 2, min segment length in pixels; shorter segments are discarded as noise
FG_LEVEL, 0, monoc value treated as foreground (digit ink)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous, active-low reset
pix_valid  in  1  current xpos/ypos/monoc valid
monoc  in  1  binarized pixel
xpos  in  11  pixel column, 0..H_PIXEL-1
ypos  in  11  pixel line, 0..V_PIXEL-1
row_border_addr  in  11  row file address; 2k = low (top) of row k, 2k+1 = high (bottom)
row_border_data  out  11  combinational read of row file
col_border_addr  in  11  col file address; 2k = left of col k, 2k+1 = right
col_border_data  out  11  combinational read of col file
frame_cnt  out  2  frame phase 0..3
project_done_flag  out  1  borders/counts valid
num_row  out  4  stored row segments
num_col  out  4  stored column segments
seg_overflow  out  1  more segments found than MAX_ROW/MAX_COL in last projection

Behaviour:
- Reset (async, active-low): frame_cnt=0, project_done_flag=0, num_row=num_col=0, seg_overflow=0, both files cleared to 0, FSM=ACCUM.
- Frame end event: pix_valid && xpos==H_PIXEL-1 && ypos==V_PIXEL-1. On it, frame_cnt increments mod 4.
- Line end event: pix_valid && xpos==H_PIXEL-1.
- Foreground pixel: pix_valid && monoc==FG_LEVEL.
- FSM ACCUM (active while frame_cnt==0):
  - Row projection: line_fg is ORed over each line. At line end, line_fg is compared with prev_fg.
    - 0→1: open a segment, start=ypos.
    - 1→0: close it, end=ypos-1.
    - Closed segment with end-start+1 ≥ MIN_SEG and row count < MAX_ROW: write low=start to addr 2k and high=end to addr 2k+1, then k++.
    - Valid segment found when count is already MAX_ROW: set seg_overflow.
    - Segment still open at frame end: closed with end=V_PIXEL-1.
  - Column projection: H_PIXEL×1 column-flag memory, read-modify-write per pixel.
    - On ypos==0 the flag is written as fg (no OR); on other lines it is written as flag OR fg.
  - At the start of each ACCUM frame (first valid pixel, xpos==0 && ypos==0): row count, seg_overflow and all row/col file entries are cleared.
  - Frame end → SCAN.
- FSM SCAN:
  - Reads column flags x=0..H_PIXEL-1, one per clk, independent of pix_valid. Read latency is 1.
  - Same open/close/MIN_SEG/MAX_COL rules as rows, applied to the col file.
  - A segment still open at x=H_PIXEL-1 closes with right=H_PIXEL-1.
  - Takes H_PIXEL+2 cycles; incoming pixels are ignored.
  - On completion, in one cycle: num_row, num_col and seg_overflow are published, project_done_flag=1, → DONE.
  - A frame end during SCAN still increments frame_cnt, and the scan continues.
- FSM DONE:
  - File contents and counts are frozen; the flag is held high.
  - At the frame end where frame_cnt wraps 3→0, the flag goes low in that same cycle and the FSM → ACCUM.
- Empty projection: counts are 0, and the flag still asserts.
- Read ports: data = file[addr] combinationally. Addresses ≥ 2*MAX_ROW (resp. 2*MAX_COL) return 0.
- Segment length uses 11-bit unsigned arithmetic. end ≥ start is guaranteed by construction.

Test Plan:
- Single block, rows 100..149, cols 200..229, FG=0 → after first SCAN: num_row=1, num_col=1; row addr0=100, addr1=149; col addr0=200, addr1=229; flag=1 during frame_cnt 1..3.
- Three digits, cols 50..79, 150..179, 250..279, rows 60..120 → num_col=3; col file holds 50,79,150,179,250,279; flag drops at the frame end where frame_cnt goes 3→0.
- Single-pixel noise column at x=10 plus block cols 20..40, MIN_SEG=2 → num_col=1, left=20, right=40.
- 10 one-column-gap segments, each 3 wide, MAX_COL=8 → num_col=8, seg_overflow=1; addrs 16..17 read 0.
- Block touching the edges, rows 250..271, cols 460..479 → high=271, right=479; then an all-background frame → num_row=num_col=0, flag=1.
- rst_n low for 3 cycles mid-SCAN → flag=0, frame_cnt=0, counts 0, files 0; the next frame reprojects correctly.
